// File: rtl/ram_wr_sched_pkg.sv
// ----------------------------------------------------------------------------
// ram_sched_pkg
// Shared definitions for the replicated-RAM write scheduler:
//   - calc_aw / calc_depth : address width and depth derived from BLOCKSIZE
//   - clog2                : index width helper (never returns less than 1)
//   - state_t              : scheduler FSM encoding (INIT sweep / RUN)
//   - DEFAULT_INIT_VAL     : word written to every address during the sweep
// No ports (package).
// ----------------------------------------------------------------------------
package ram_sched_pkg;

    // BLOCKSIZE is the address MSB index, so the width is one more.
    function automatic int calc_aw(input int blocksize);
        return blocksize + 1;
    endfunction

    function automatic int calc_depth(input int aw);
        return 1 << aw;
    endfunction

    // Width needed to index n items; a single item still gets one bit so
    // that index ports never collapse to zero width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [31:0] DEFAULT_INIT_VAL = 32'h0;

endpackage

// File: rtl/ram_wr_sched_if.sv
// ----------------------------------------------------------------------------
// ram_wr_sched_if
// Bundle between the write requesters and the scheduler, plus the RAM write
// port the scheduler drives.
//   clr_req    : restart the initialization sweep (single-cycle pulse)
//   req_valid  : per-requester write request
//   req_addr   : packed addresses, requester i at [i*AW +: AW]
//   req_data   : packed data,      requester i at [i*DW +: DW]
//   req_ready  : one-hot grant back to the requesters
//   w_enb/w_addr/w_din : shared RAM write port
//   grant_id   : requester behind the current w_enb
//   init_done  : sweep finished, scheduler arbitrating
// Modports: master = requester side, slave = scheduler side.
// ----------------------------------------------------------------------------
interface ram_wr_sched_if
    import ram_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = 11,
    parameter int DW   = 32,
    parameter int IW   = clog2(NREQ)
);
    logic                 clr_req;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 w_enb;
    logic [AW-1:0]        w_addr;
    logic [DW-1:0]        w_din;
    logic [IW-1:0]        grant_id;
    logic                 init_done;

    modport master (
        output clr_req, req_valid, req_addr, req_data,
        input  req_ready, w_enb, w_addr, w_din, grant_id, init_done
    );

    modport slave (
        input  clr_req, req_valid, req_addr, req_data,
        output req_ready, w_enb, w_addr, w_din, grant_id, init_done
    );
endinterface

// File: rtl/ram_wr_sched_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Scans requests starting at i_ptr and
// grants the first asserted one.
//   i_req : request vector
//   i_ptr : highest-priority index this cycle (must be < N)
//   i_en  : when low no grant is issued
//   o_gnt : one-hot grant (all-zero when nothing granted)
//   o_idx : binary index of the grant (0 when nothing granted)
// ----------------------------------------------------------------------------
module rr_arbiter
    import ram_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);
    // w_cand[gi] is the requester examined at priority position gi.
    logic [IW-1:0] w_cand [N];
    logic [N-1:0]  w_hit;
    logic [N:0]    w_seen;
    logic [IW-1:0] w_idx_acc [N+1];

    assign w_seen[0]    = 1'b0;
    assign w_idx_acc[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_scan
            assign w_cand[gi]      = IW'((int'(i_ptr) + gi) % N);
            // Only the first hit in priority order survives the chain.
            assign w_hit[gi]       = i_en && !w_seen[gi] && i_req[w_cand[gi]];
            assign w_seen[gi+1]    = w_seen[gi] | w_hit[gi];
            assign w_idx_acc[gi+1] = w_idx_acc[gi] | ({IW{w_hit[gi]}} & w_cand[gi]);
        end
    endgenerate

    assign o_idx = w_idx_acc[N];
    assign o_gnt = w_seen[N] ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/ram_wr_sched.sv
// ----------------------------------------------------------------------------
// ram_wr_sched
// Write-side controller for the replicated 8R1W RAM. After reset (and on a
// clear request while running) it sweeps INIT_VAL into every address, then
// arbitrates NREQ requesters round-robin onto the single write port.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : ram_wr_sched_if.slave (requests in, grant and RAM write port out)
// Write port outputs are registered; req_ready is combinational.
// ----------------------------------------------------------------------------
module ram_wr_sched
    import ram_sched_pkg::*;
#(
    parameter int             BLOCKSIZE = 10,
    parameter int             NREQ      = 4,
    parameter int             DW        = 32,
    parameter logic [DW-1:0]  INIT_VAL  = DW'(DEFAULT_INIT_VAL)
) (
    input  logic          clk,
    input  logic          rst,
    ram_wr_sched_if.slave bus
);
    localparam int            AW        = calc_aw(BLOCKSIZE);
    localparam int            DEPTH     = calc_depth(AW);
    localparam int            IW        = clog2(NREQ);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        r_state,     w_state_next;
    logic [AW-1:0] r_cnt,       w_cnt_next;
    logic [IW-1:0] r_ptr,       w_ptr_next;
    logic          r_w_enb,     w_w_enb_next;
    logic [AW-1:0] r_w_addr,    w_w_addr_next;
    logic [DW-1:0] r_w_din,     w_w_din_next;
    logic [IW-1:0] r_grant_id,  w_grant_id_next;
    logic          r_init_done, w_init_done_next;

    logic [AW-1:0] w_addr_arr [NREQ];
    logic [DW-1:0] w_data_arr [NREQ];
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0] w_idx;
    logic          w_arb_en;
    logic          w_accept;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_addr_arr[gi] = bus.req_addr[gi*AW +: AW];
            assign w_data_arr[gi] = bus.req_data[gi*DW +: DW];
        end
    endgenerate

    // A clear request blocks the grant in its own cycle so the sweep can
    // start cleanly on the next edge without a competing write.
    assign w_arb_en = (r_state == RUN) && !bus.clr_req;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .i_en  (w_arb_en),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_accept      = |(bus.req_valid & w_gnt);
    assign bus.req_ready = w_gnt;
    assign bus.w_enb     = r_w_enb;
    assign bus.w_addr    = r_w_addr;
    assign bus.w_din     = r_w_din;
    assign bus.grant_id  = r_grant_id;
    assign bus.init_done = r_init_done;

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_ptr_next       = r_ptr;
        w_w_enb_next     = 1'b0;
        w_w_addr_next    = r_w_addr;
        w_w_din_next     = r_w_din;
        w_grant_id_next  = r_grant_id;
        w_init_done_next = r_init_done;

        case (r_state)
            INIT: begin
                // clr_req is deliberately not looked at here.
                w_w_enb_next  = 1'b1;
                w_w_addr_next = r_cnt;
                w_w_din_next  = INIT_VAL;
                w_cnt_next    = r_cnt + AW'(1);
                if (r_cnt == LAST_ADDR) begin
                    w_state_next     = RUN;
                    w_cnt_next       = '0;
                    w_init_done_next = 1'b1;
                end
            end
            RUN: begin
                if (bus.clr_req) begin
                    w_state_next     = INIT;
                    w_cnt_next       = '0;
                    w_init_done_next = 1'b0;
                end else if (w_accept) begin
                    w_w_enb_next    = 1'b1;
                    w_w_addr_next   = w_addr_arr[w_idx];
                    w_w_din_next    = w_data_arr[w_idx];
                    w_grant_id_next = w_idx;
                    w_ptr_next      = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
                end
            end
            default: begin
                w_state_next = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= INIT;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_w_enb     <= 1'b0;
            r_w_addr    <= '0;
            r_w_din     <= '0;
            r_grant_id  <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_ptr       <= w_ptr_next;
            r_w_enb     <= w_w_enb_next;
            r_w_addr    <= w_w_addr_next;
            r_w_din     <= w_w_din_next;
            r_grant_id  <= w_grant_id_next;
            r_init_done <= w_init_done_next;
        end
    end

endmodule

// File: tb/tb_ram_wr_sched.sv
// ----------------------------------------------------------------------------
// tb_ram_wr_sched
// Directed bench for ram_wr_sched with BLOCKSIZE=3 (DEPTH=16), NREQ=4.
// A behavioural model (sweep position, rr pointer, expected write port)
// is compared against the DUT on every falling edge; directed sequences add
// hand-computed literal checks.
// ----------------------------------------------------------------------------
module tb_ram_wr_sched;
    import ram_sched_pkg::*;

    localparam int BLOCKSIZE = 3;
    localparam int NREQ      = 4;
    localparam int DW        = 32;
    localparam int AW        = 4;
    localparam int DEPTH     = 16;
    localparam int IW        = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ram_wr_sched_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    ram_wr_sched #(
        .BLOCKSIZE (BLOCKSIZE),
        .NREQ      (NREQ),
        .DW        (DW),
        .INIT_VAL  (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              m_init;
    int              m_pos;
    int              m_ptr;
    int              m_k;
    logic [NREQ-1:0] m_ready;
    logic            exp_enb;
    logic            exp_done;
    logic [AW-1:0]   exp_addr;
    logic [DW-1:0]   exp_din;
    logic [IW-1:0]   exp_gid;

    // First valid requester scanning from p upward, modulo NREQ; -1 if none.
    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int j = 0; j < NREQ; j++) begin
            int k;
            k = (p + j) % NREQ;
            if (((v >> k) & 4'd1) != 4'd0) return k;
        end
        return -1;
    endfunction

    always_comb m_k = pick(bus.req_valid, m_ptr);

    always_comb begin
        m_ready = '0;
        if (!m_init && !bus.clr_req && m_k >= 0) m_ready = 4'(1) << m_k;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_init   <= 1'b1;
            m_pos    <= 0;
            m_ptr    <= 0;
            exp_enb  <= 1'b0;
            exp_addr <= '0;
            exp_din  <= '0;
            exp_gid  <= '0;
            exp_done <= 1'b0;
        end else if (m_init) begin
            exp_enb  <= 1'b1;
            exp_addr <= AW'(m_pos);
            exp_din  <= 32'h0;
            if (m_pos == DEPTH - 1) begin
                m_init   <= 1'b0;
                m_pos    <= 0;
                exp_done <= 1'b1;
            end else begin
                m_pos <= m_pos + 1;
            end
        end else if (bus.clr_req) begin
            m_init   <= 1'b1;
            m_pos    <= 0;
            exp_done <= 1'b0;
            exp_enb  <= 1'b0;
        end else if (m_k >= 0) begin
            exp_enb  <= 1'b1;
            exp_addr <= bus.req_addr[m_k*AW +: AW];
            exp_din  <= bus.req_data[m_k*DW +: DW];
            exp_gid  <= IW'(m_k);
            m_ptr    <= (m_k + 1) % NREQ;
        end else begin
            exp_enb <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("cyc_w_enb",     32'(bus.w_enb),     32'(exp_enb));
        check("cyc_w_addr",    32'(bus.w_addr),    32'(exp_addr));
        check("cyc_w_din",     32'(bus.w_din),     32'(exp_din));
        check("cyc_grant_id",  32'(bus.grant_id),  32'(exp_gid));
        check("cyc_init_done", 32'(bus.init_done), 32'(exp_done));
        check("cyc_req_ready", 32'(bus.req_ready), 32'(m_ready));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    int seq_all[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int seq_drop[4] = '{0, 2, 3, 0};

    initial begin
        bus.clr_req   = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_w_enb",     32'(bus.w_enb),     32'(0));
        check("rst_init_done", 32'(bus.init_done), 32'(0));
        check("rst_w_addr",    32'(bus.w_addr),    32'(0));

        // 1: init sweep with every requester already valid
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), 32'h1000 + 32'(i));
        bus.req_valid = 4'b1111;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check("t1_ready", 32'(bus.req_ready), 32'(0));
            tick();
            check("t1_enb",  32'(bus.w_enb),     32'(1));
            check("t1_addr", 32'(bus.w_addr),    32'(i));
            check("t1_din",  bus.w_din,          32'h0);
            check("t1_done", 32'(bus.init_done), 32'(i == DEPTH - 1));
        end
        bus.req_valid = 4'b0000;

        // 2: single requester
        set_req(2, 4'd5, 32'hDEADBEEF);
        bus.req_valid = 4'b0100;
        #1;
        check("t2_ready", 32'(bus.req_ready), 32'(4'b0100));
        tick();
        bus.req_valid = 4'b0000;
        check("t2_enb",  32'(bus.w_enb),    32'(1));
        check("t2_addr", 32'(bus.w_addr),   32'(5));
        check("t2_din",  bus.w_din,         32'hDEADBEEF);
        check("t2_gid",  32'(bus.grant_id), 32'(2));
        tick();
        check("t2_idle_enb",  32'(bus.w_enb),  32'(0));
        check("t2_hold_addr", 32'(bus.w_addr), 32'(5));

        // 3: requester 3 alone brings ptr to 0, then all four contend
        bus.req_valid = 4'b1000;
        tick();
        check("t3_pre_gid", 32'(bus.grant_id), 32'(3));
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(8 + i), 32'hC0DE0000 + 32'(i));
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("t3_enb",  32'(bus.w_enb),    32'(1));
            check("t3_gid",  32'(bus.grant_id), 32'(seq_all[c]));
            check("t3_addr", 32'(bus.w_addr),   32'(8 + seq_all[c]));
        end
        bus.req_valid = 4'b1101;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t3_skip_gid", 32'(bus.grant_id), 32'(seq_drop[c]));
        end
        bus.req_valid = 4'b0000;
        tick();
        check("t3_idle_enb", 32'(bus.w_enb), 32'(0));

        // 4: ptr=3 with only requesters 0 and 1 valid -> wrap-around
        bus.req_valid = 4'b0100;
        tick();
        check("t4_pre_gid", 32'(bus.grant_id), 32'(2));
        bus.req_valid = 4'b0011;
        #1;
        check("t4_ready0", 32'(bus.req_ready), 32'(4'b0001));
        tick();
        check("t4_gid0", 32'(bus.grant_id), 32'(0));
        check("t4_ready1", 32'(bus.req_ready), 32'(4'b0010));
        tick();
        check("t4_gid1", 32'(bus.grant_id), 32'(1));
        bus.req_valid = 4'b0000;
        tick();

        // 5: clear while requester 1 waits; clr during the sweep is ignored
        set_req(1, 4'd3, 32'h00000055);
        bus.req_valid = 4'b0010;
        bus.clr_req   = 1'b1;
        #1;
        check("t5_clr_ready", 32'(bus.req_ready), 32'(0));
        tick();
        bus.clr_req = 1'b0;
        check("t5_clr_enb",  32'(bus.w_enb),     32'(0));
        check("t5_clr_done", 32'(bus.init_done), 32'(0));
        for (int i = 0; i < DEPTH; i++) begin
            check("t5_ready", 32'(bus.req_ready), 32'(0));
            if (i == 5) bus.clr_req = 1'b1;
            tick();
            bus.clr_req = 1'b0;
            check("t5_addr", 32'(bus.w_addr),    32'(i));
            check("t5_done", 32'(bus.init_done), 32'(i == DEPTH - 1));
        end
        check("t5_run_ready", 32'(bus.req_ready), 32'(4'b0010));
        tick();
        bus.req_valid = 4'b0000;
        check("t5_gid",  32'(bus.grant_id), 32'(1));
        check("t5_addr_run", 32'(bus.w_addr), 32'(3));

        // 6: asynchronous reset mid-sweep
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("t6_pre_addr", 32'(bus.w_addr), 32'(7));
        rst = 1'b1;
        #1;
        check("t6_rst_enb",  32'(bus.w_enb),     32'(0));
        check("t6_rst_done", 32'(bus.init_done), 32'(0));
        tick();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            check("t6_addr", 32'(bus.w_addr),    32'(i));
            check("t6_done", 32'(bus.init_done), 32'(i == DEPTH - 1));
        end
        set_req(3, 4'd9, 32'h0BADF00D);
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = 4'b0000;
        check("t6_run_gid", 32'(bus.grant_id), 32'(3));
        check("t6_run_din", bus.w_din,         32'h0BADF00D);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
